// File: rtl/vram_host_arbiter.sv
// Shares one single-port, registered-read VRAM between the display readout path
// (never preempted) and an asynchronous host bus with one posted write and one pending read.
module vram_host_arbiter #(
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] hostAddr,
  input  logic [DATA_W-1:0] hostDataIn,
  input  logic              nHostWr,
  input  logic              nHostRd,
  output logic [DATA_W-1:0] hostDataOut,
  output logic              hostDataOe,
  output logic              hostBusy,
  output logic              wrDropped,
  input  logic              dispReq,
  input  logic [ADDR_W-1:0] dispAddr,
  output logic [DATA_W-1:0] dispData,
  output logic              dispValid,
  output logic [ADDR_W-1:0] vramAddr,
  output logic [DATA_W-1:0] vramWrData,
  output logic              vramWr,
  input  logic [DATA_W-1:0] vramRdData
);

  typedef enum logic [1:0] {GNT_IDLE, GNT_DISP, GNT_HWR, GNT_HRD} grant_e;

  grant_e                 grant_q, grant_d;
  logic [SYNC_STAGES-1:0] wr_sync_q, rd_sync_q;
  logic                   wr_hist_q, rd_hist_q;
  logic                   wr_synced, rd_synced, wr_edge, rd_edge;
  logic                   wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d, last_addr_q;
  logic [DATA_W-1:0]      wr_data_q, wr_data_d, host_data_q, host_data_d;
  logic                   rd_done_q, rd_done_d, busy_q, busy_d, wr_dropped_q, wr_dropped_d;

  assign wr_synced = wr_sync_q[SYNC_STAGES-1];
  assign rd_synced = rd_sync_q[SYNC_STAGES-1];
  assign wr_edge   = ~wr_synced & wr_hist_q;
  assign rd_edge   = ~rd_synced & rd_hist_q;

  // State registers; strobe synchronisers idle high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_sync_q    <= '1;
      rd_sync_q    <= '1;
      wr_hist_q    <= 1'b1;
      rd_hist_q    <= 1'b1;
      grant_q      <= GNT_IDLE;
      wr_pend_q    <= 1'b0;
      rd_pend_q    <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      rd_addr_q    <= '0;
      last_addr_q  <= '0;
      host_data_q  <= '0;
      rd_done_q    <= 1'b0;
      busy_q       <= 1'b0;
      wr_dropped_q <= 1'b0;
    end else begin
      wr_sync_q    <= {wr_sync_q[SYNC_STAGES-2:0], nHostWr};
      rd_sync_q    <= {rd_sync_q[SYNC_STAGES-2:0], nHostRd};
      wr_hist_q    <= wr_synced;
      rd_hist_q    <= rd_synced;
      grant_q      <= grant_d;
      wr_pend_q    <= wr_pend_d;
      rd_pend_q    <= rd_pend_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      rd_addr_q    <= rd_addr_d;
      last_addr_q  <= vramAddr;
      host_data_q  <= host_data_d;
      rd_done_q    <= rd_done_d;
      busy_q       <= busy_d;
      wr_dropped_q <= wr_dropped_d;
    end
  end

  // Grant, VRAM drive and buffer next-state
  always_comb begin
    grant_d      = GNT_IDLE;
    vramAddr     = last_addr_q;
    vramWrData   = '0;
    vramWr       = 1'b0;
    wr_pend_d    = wr_pend_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    rd_pend_d    = rd_pend_q;
    rd_addr_d    = rd_addr_q;
    host_data_d  = host_data_q;
    rd_done_d    = rd_done_q;
    wr_dropped_d = wr_edge & wr_pend_q;

    // A read already in flight is not reissued while its data returns
    if (dispReq) begin
      grant_d = GNT_DISP;
    end else if (wr_pend_q) begin
      grant_d = GNT_HWR;
    end else if (rd_pend_q && (grant_q != GNT_HRD)) begin
      grant_d = GNT_HRD;
    end

    unique case (grant_d)
      GNT_DISP: vramAddr = dispAddr;
      GNT_HWR: begin
        vramAddr   = wr_addr_q;
        vramWrData = wr_data_q;
        vramWr     = 1'b1;
        wr_pend_d  = 1'b0;
      end
      GNT_HRD:  vramAddr = rd_addr_q;
      default:  ;
    endcase

    if (wr_edge && !wr_pend_q) begin
      wr_pend_d = 1'b1;
      wr_addr_d = hostAddr;
      wr_data_d = hostDataIn;
    end

    if (rd_synced) begin
      rd_done_d = 1'b0;
    end
    if (grant_q == GNT_HRD) begin
      host_data_d = vramRdData;
      rd_pend_d   = 1'b0;
      rd_done_d   = 1'b1;
    end

    if (rd_edge && !rd_pend_q) begin
      rd_pend_d = 1'b1;
      rd_addr_d = hostAddr;
    end

    busy_d = wr_pend_d | rd_pend_d;
  end

  assign hostDataOut = host_data_q;
  assign hostDataOe  = rd_done_q & ~rd_synced;
  assign hostBusy    = busy_q;
  assign wrDropped   = wr_dropped_q;
  assign dispValid   = (grant_q == GNT_DISP);
  assign dispData    = dispValid ? vramRdData : '0;

endmodule

// File: tb/tb_vram_host_arbiter.sv
// Scoreboard bench for vram_host_arbiter with a behavioural single-port registered-read VRAM.
module tb_vram_host_arbiter;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] hostAddr;
  logic [DATA_W-1:0] hostDataIn;
  logic              nHostWr, nHostRd;
  logic [DATA_W-1:0] hostDataOut;
  logic              hostDataOe, hostBusy, wrDropped;
  logic              dispReq;
  logic [ADDR_W-1:0] dispAddr;
  logic [DATA_W-1:0] dispData;
  logic              dispValid;
  logic [ADDR_W-1:0] vramAddr;
  logic [DATA_W-1:0] vramWrData;
  logic              vramWr;
  logic [DATA_W-1:0] vramRdData;

  logic [DATA_W-1:0]        mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W+DATA_W-1:0] exp_wr_q[$];
  logic [DATA_W-1:0]        exp_disp_q[$];
  logic [DATA_W-1:0]        exp_rd_q[$];

  int nchecks = 0;
  int nerrors = 0;
  int wr_count = 0;
  int disp_count = 0;
  int drop_count = 0;
  bit disp_chk_en = 1'b1;

  vram_host_arbiter #(.ADDR_W(13), .DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .hostAddr(hostAddr), .hostDataIn(hostDataIn), .nHostWr(nHostWr), .nHostRd(nHostRd),
    .hostDataOut(hostDataOut), .hostDataOe(hostDataOe), .hostBusy(hostBusy), .wrDropped(wrDropped),
    .dispReq(dispReq), .dispAddr(dispAddr), .dispData(dispData), .dispValid(dispValid),
    .vramAddr(vramAddr), .vramWrData(vramWrData), .vramWr(vramWr), .vramRdData(vramRdData)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input logic [12:0] a);
    return 8'(a * 13'd7 + 13'd3);
  endfunction

  always @(posedge clk) begin
    if (vramWr) mem[vramAddr] <= vramWrData;
    vramRdData <= mem[vramAddr];
  end

  // Scoreboard monitor: VRAM writes and display returns
  always @(negedge clk) begin
    logic [ADDR_W+DATA_W-1:0] w;
    logic [DATA_W-1:0]        d;
    if (!rst) begin
      if (vramWr) begin
        wr_count++;
        nchecks++;
        if (exp_wr_q.size() == 0) begin
          nerrors++;
          $display("FAIL vram_wr_unexpected: got addr=%h data=%h, expected no write", vramAddr, vramWrData);
        end else begin
          w = exp_wr_q.pop_front();
          if ({vramAddr, vramWrData} !== w) begin
            nerrors++;
            $display("FAIL vram_wr: got addr=%h data=%h, expected addr=%h data=%h",
                     vramAddr, vramWrData, w[20:8], w[7:0]);
          end
        end
      end
      if (dispValid && disp_chk_en) begin
        disp_count++;
        nchecks++;
        if (exp_disp_q.size() == 0) begin
          nerrors++;
          $display("FAIL disp_unexpected: got dispValid with data=%h", dispData);
        end else begin
          d = exp_disp_q.pop_front();
          if (dispData !== d) begin
            nerrors++;
            $display("FAIL disp_data: got %h, expected %h", dispData, d);
          end
        end
      end
      if (wrDropped) drop_count++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic host_read(input logic [12:0] a, input logic [7:0] d);
    bit seen;
    logic [7:0] e;
    hostAddr = a;
    nHostRd  = 1'b0;
    exp_rd_q.push_back(d);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (hostDataOe) seen = 1'b1;
    end
    nchecks++;
    if (!seen) begin
      nerrors++;
      $display("FAIL rd_oe_timeout: hostDataOe=0 after 40 cycles, expected 1");
      void'(exp_rd_q.pop_front());
    end else begin
      e = exp_rd_q.pop_front();
      nchecks++;
      if (hostDataOut !== e) begin
        nerrors++;
        $display("FAIL rd_data: got %h, expected %h", hostDataOut, e);
      end
    end
    repeat (3) @(negedge clk);
    nchecks++;
    if (hostDataOe !== 1'b1) begin
      nerrors++;
      $display("FAIL rd_oe_hold: got %b, expected 1", hostDataOe);
    end
    @(posedge clk); #2;
    nHostRd = 1'b1;
    step(4);
    @(negedge clk);
    nchecks++;
    if (hostDataOe !== 1'b0) begin
      nerrors++;
      $display("FAIL rd_oe_release: got %b, expected 0", hostDataOe);
    end
  endtask

  task automatic test_reset();
    int wr_seen;
    rst = 1'b1; nHostWr = 1'b1; nHostRd = 1'b1; dispReq = 1'b0;
    dispAddr = '0; hostAddr = '0; hostDataIn = '0;
    wr_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (vramWr) wr_seen++;
    end
    nchecks++; if (wr_seen != 0) begin nerrors++; $display("FAIL rst_vramWr: got %0d writes, expected 0", wr_seen); end
    nchecks++; if (hostDataOut !== 8'h00) begin nerrors++; $display("FAIL rst_hostDataOut: got %h, expected 00", hostDataOut); end
    nchecks++; if (hostDataOe !== 1'b0) begin nerrors++; $display("FAIL rst_hostDataOe: got %b, expected 0", hostDataOe); end
    nchecks++; if (hostBusy !== 1'b0) begin nerrors++; $display("FAIL rst_hostBusy: got %b, expected 0", hostBusy); end
    nchecks++; if (wrDropped !== 1'b0) begin nerrors++; $display("FAIL rst_wrDropped: got %b, expected 0", wrDropped); end
    nchecks++; if (dispValid !== 1'b0) begin nerrors++; $display("FAIL rst_dispValid: got %b, expected 0", dispValid); end
    nchecks++; if (dispData !== 8'h00) begin nerrors++; $display("FAIL rst_dispData: got %h, expected 00", dispData); end
    nchecks++; if (vramAddr !== 13'h0) begin nerrors++; $display("FAIL rst_vramAddr: got %h, expected 0", vramAddr); end
    nchecks++; if (vramWrData !== 8'h00) begin nerrors++; $display("FAIL rst_vramWrData: got %h, expected 00", vramWrData); end
    @(posedge clk); #2;
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_write_read();
    int wr0;
    wr0 = wr_count;
    dispReq = 1'b0;
    hostAddr = 13'h0123; hostDataIn = 8'hA5;
    exp_wr_q.push_back({13'h0123, 8'hA5});
    nHostWr = 1'b0;
    step(6);
    nHostWr = 1'b1;
    step(3);
    host_read(13'h0123, 8'hA5);
    @(negedge clk); #1;
    nchecks++;
    if (wr_count != wr0 + 1) begin
      nerrors++;
      $display("FAIL wr_once: got %0d writes, expected 1", wr_count - wr0);
    end
  endtask

  task automatic test_disp_starve();
    int wr0, dv0;
    wr0 = wr_count; dv0 = disp_count;
    hostAddr = 13'h0200; hostDataIn = 8'h3C;
    exp_wr_q.push_back({13'h0200, 8'h3C});
    for (int i = 0; i < 20; i++) begin
      dispReq  = 1'b1;
      dispAddr = 13'h1000 + 13'(i);
      exp_disp_q.push_back(pat(13'h1000 + 13'(i)));
      if (i == 0) nHostWr = 1'b0;
      if (i == 6) nHostWr = 1'b1;
      step(1);
    end
    nchecks++;
    if (hostBusy !== 1'b1) begin nerrors++; $display("FAIL starve_busy: got %b, expected 1", hostBusy); end
    nchecks++;
    if (wr_count != wr0) begin nerrors++; $display("FAIL starve_no_wr: got %0d writes, expected 0", wr_count - wr0); end
    dispReq = 1'b0;
    @(negedge clk); #1;
    nchecks++;
    if (wr_count != wr0 + 1) begin nerrors++; $display("FAIL starve_wr_first_free: got %0d writes, expected 1", wr_count - wr0); end
    step(2);
    @(negedge clk); #1;
    nchecks++;
    if (disp_count != dv0 + 20) begin nerrors++; $display("FAIL starve_disp_count: got %0d, expected 20", disp_count - dv0); end
  endtask

  task automatic test_drop();
    int dr0;
    dr0 = drop_count;
    exp_wr_q.push_back({13'h0010, 8'h11});
    for (int i = 0; i < 24; i++) begin
      dispReq  = 1'b1;
      dispAddr = 13'h1100 + 13'(i);
      exp_disp_q.push_back(pat(13'h1100 + 13'(i)));
      if (i == 0)  begin hostAddr = 13'h0010; hostDataIn = 8'h11; nHostWr = 1'b0; end
      if (i == 6)  nHostWr = 1'b1;
      if (i == 10) begin hostAddr = 13'h0010; hostDataIn = 8'h22; nHostWr = 1'b0; end
      if (i == 16) nHostWr = 1'b1;
      step(1);
    end
    dispReq = 1'b0;
    step(4);
    @(negedge clk); #1;
    nchecks++;
    if (drop_count != dr0 + 1) begin nerrors++; $display("FAIL drop_pulse: got %0d pulses, expected 1", drop_count - dr0); end
    nchecks++;
    if (mem[13'h0010] !== 8'h11) begin nerrors++; $display("FAIL drop_mem: got %h, expected 11", mem[13'h0010]); end
    nchecks++;
    if (hostBusy !== 1'b0) begin nerrors++; $display("FAIL drop_busy_clear: got %b, expected 0", hostBusy); end
  endtask

  task automatic test_same_cycle();
    int wr0;
    wr0 = wr_count;
    dispReq = 1'b0;
    hostAddr = 13'h1FFF; hostDataIn = 8'h5A;
    exp_wr_q.push_back({13'h1FFF, 8'h5A});
    nHostWr = 1'b0;
    host_read(13'h1FFF, 8'h5A);
    nHostWr = 1'b1;
    step(4);
    nchecks++;
    if (wr_count != wr0 + 1) begin nerrors++; $display("FAIL same_cycle_wr: got %0d writes, expected 1", wr_count - wr0); end
  endtask

  task automatic test_reset_mid_read();
    int bad;
    disp_chk_en = 1'b0;
    dispReq = 1'b1; dispAddr = 13'h1200;
    hostAddr = 13'h0050;
    nHostRd = 1'b0;
    step(6);
    @(negedge clk); #1;
    nchecks++;
    if (hostBusy !== 1'b1) begin nerrors++; $display("FAIL midrst_busy_before: got %b, expected 1", hostBusy); end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    nchecks++;
    if (hostBusy !== 1'b0) begin nerrors++; $display("FAIL midrst_busy_async: got %b, expected 0", hostBusy); end
    nchecks++;
    if (hostDataOe !== 1'b0) begin nerrors++; $display("FAIL midrst_oe_async: got %b, expected 0", hostDataOe); end
    nHostRd = 1'b1; dispReq = 1'b0;
    step(2);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (vramAddr == 13'h0050 || hostBusy || hostDataOe) bad++;
    end
    nchecks++;
    if (bad != 0) begin nerrors++; $display("FAIL midrst_no_hrd: got %0d bad cycles, expected 0", bad); end
    exp_disp_q.delete();
    disp_chk_en = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = pat(13'(i));
    test_reset();
    test_write_read();
    test_disp_starve();
    test_drop();
    test_same_cycle();
    test_reset_mid_read();
    nchecks++;
    if (exp_wr_q.size() != 0 || exp_disp_q.size() != 0 || exp_rd_q.size() != 0) begin
      nerrors++;
      $display("FAIL scoreboard_drain: got wr=%0d disp=%0d rd=%0d left, expected 0",
               exp_wr_q.size(), exp_disp_q.size(), exp_rd_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/vram_host_arbiter.md
Name: vram_host_arbiter

Overview:
- Shares a single-port, registered-read VRAM between two requesters: the display readout path and the asynchronous host bus.
- Synchronises the host strobes, buffers one posted write and one pending read, and schedules both into cycles the display does not claim.
- Returns read data to the display and drives host read data plus its output enable.
- Sits between the readout/pixgen path and a single-port vram instance; the mirrored dual-port VRAM is no longer needed.

Parameters:
- ADDR_W, 13, VRAM address width
- DATA_W, 8, VRAM data width
- SYNC_STAGES, 2, host strobe synchroniser depth (min 2)

Ports:
- clk  in  1  VGA dot clock
- rst  in  1  asynchronous, active-high reset
- hostAddr  in  ADDR_W  host address, asynchronous
- hostDataIn  in  DATA_W  host write data, asynchronous
- nHostWr  in  1  host write strobe, active-low, asynchronous
- nHostRd  in  1  host read strobe, active-low, asynchronous
- hostDataOut  out  DATA_W  host read data
- hostDataOe  out  1  enables host data-bus drivers at the top level
- hostBusy  out  1  a host write or read is pending
- wrDropped  out  1  one-cycle pulse: a host write was discarded
- dispReq  in  1  display claims VRAM this cycle
- dispAddr  in  ADDR_W  display read address
- dispData  out  DATA_W  display read data
- dispValid  out  1  dispData valid this cycle
- vramAddr  out  ADDR_W  VRAM address
- vramWrData  out  DATA_W  VRAM write data
- vramWr  out  1  VRAM write enable
- vramRdData  in  DATA_W  VRAM read data, one cycle after address

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0. Synchroniser flops reset to 1 (strobes idle). Pending flags clear.
- Strobe synchronisation: nHostWr and nHostRd each pass through SYNC_STAGES flops, plus one history flop. An assert edge is synced-low with history high.
- Write capture: on a write edge, latch hostAddr/hostDataIn into the write buffer and set wrPend.
  - Host holds address/data stable from strobe assertion until SYNC_STAGES+1 clocks later.
- Read capture: on a read edge, latch hostAddr into the read buffer and set rdPend.
- Write edge with wrPend already set: discard the new write, keep the buffered one, pulse wrDropped.
  - A read edge with rdPend set is treated the same way; no flag is raised.
- Grant, evaluated every cycle, strict priority:
  - DISP: dispReq=1. Drive vramAddr=dispAddr, vramWr=0.
  - HWR: else wrPend=1. Drive buffered addr/data, vramWr=1, clear wrPend at the clock edge.
  - HRD: else rdPend=1. Drive buffered addr, vramWr=0.
  - IDLE: otherwise. vramWr=0, vramAddr holds its last value.
- Return routing: the grant is registered one cycle.
  - Previous grant DISP: dispValid=1, dispData=vramRdData (combinational pass-through).
  - Previous grant HRD: register vramRdData into hostDataOut, clear rdPend, set rdDone.
- hostDataOe = rdDone AND synced nHostRd low.
  - rdDone clears when synced nHostRd returns high; hostDataOe drops in the same cycle.
  - hostDataOut holds its value until the next host read completes.
- hostBusy = wrPend OR rdPend, registered.
- Ordering:
  - A pending write always beats a pending read, so a read to the same address returns the newly written data.
  - Write and read edges detected in the same cycle: both are captured; the write executes first.
- Starvation: the display is never preempted. The host waits for a cycle with dispReq=0; hostBusy stays high meanwhile.
- Reset mid-operation: pending flags, rdDone and hostDataOe clear immediately; a buffered write is lost.
- Latency with no contention (nHostRd low first sampled at edge k, SYNC_STAGES=2):
  - edge detected in cycle k+2
  - HRD issue in cycle k+3
  - hostDataOut/hostDataOe valid after edge k+4
- Write: vramWr asserted in cycle k+3.

Test Plan:
- Reset with nHostWr=nHostRd=1 -> all outputs 0, hostBusy=0, vramWr never asserted.
- dispReq=0, host write addr 0x0123 data 0xA5, then host read 0x0123 -> vramWr pulses once with addr 0x0123/data 0xA5; hostDataOut=0xA5; hostDataOe high until nHostRd rises.
- dispReq held 1 for 20 cycles while a host write is pending -> no vramWr during the 20 cycles; write issues in the first cycle dispReq=0; dispValid high for cycles 2-21 with correct data.
- Two writes (0x10/0x11 then 0x10/0x22) spaced so the second arrives while dispReq=1 holds the first pending -> wrDropped pulses once; VRAM 0x10 ends 0x11.
- Write 0x1FFF/0x5A and read 0x1FFF edges in the same cycle -> write issues first; hostDataOut=0x5A.
- rst asserted mid-read (rdPend=1) -> hostBusy, hostDataOe drop asynchronously; no HRD grant after release.
